// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: channel-side and consumer-side handshake bundle for rr_arb_mux.
// Optional packet-lock sideband (in_last/out_last) exists only when
// RR_ARB_MUX_LOCK_EN is defined.
interface rr_arb_mux_if #(
  parameter int INPUTS = 4,
  parameter int WIDTH  = 8
);
  logic [WIDTH*INPUTS-1:0] in_data;
  logic [INPUTS-1:0]       in_valid;
  logic [INPUTS-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [INPUTS-1:0]       out_grant;
  logic                    out_valid;
  logic                    out_ready;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [INPUTS-1:0]       in_last;
  logic                    out_last;
`endif

  // Arbiter side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_grant, out_valid
`ifdef RR_ARB_MUX_LOCK_EN
    , input in_last, output out_last
`endif
  );

  // Producers and consumer side
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_grant, out_valid
`ifdef RR_ARB_MUX_LOCK_EN
    , output in_last, input out_last
`endif
  );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N-input round-robin arbitrating multiplexer.
// A one-hot round-robin grant drives an AND-OR data mux into a single output
// register with valid/ready handshake; full throughput when out_ready=1.
// Optional feature macro: RR_ARB_MUX_LOCK_EN (holds the grant on one channel
// until a beat with in_last=1 transfers, so packets are never interleaved).
module rr_arb_mux #(
  parameter int INPUTS = 4,
  parameter int WIDTH  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arb_mux_if.slave  bus
);

  logic [INPUTS-1:0] r_ptr;
  logic [INPUTS-1:0] r_grant;
  logic [WIDTH-1:0]  r_data;
  logic              r_valid;

  logic [INPUTS-1:0] w_req;
  logic [INPUTS-1:0] w_grant;
  logic [WIDTH-1:0]  w_mux;
  logic              w_load;
  logic              w_xfer;
  logic              w_adv;

  assign w_load = !r_valid || bus.out_ready;
  assign w_xfer = w_load && (|w_grant);

`ifdef RR_ARB_MUX_LOCK_EN
  logic              r_locked;
  logic [INPUTS-1:0] r_lock_oh;
  logic              r_last;
  logic              w_last;

  // While locked only the locked channel may be granted
  assign w_req  = r_locked ? (bus.in_valid & r_lock_oh) : bus.in_valid;
  assign w_last = |(w_grant & bus.in_last);
  assign w_adv  = w_xfer && w_last;

  // Lock register: set by a non-last beat, cleared by a last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked  <= 1'b0;
      r_lock_oh <= '0;
      r_last    <= 1'b0;
    end else if (w_xfer) begin
      r_locked  <= !w_last;
      r_lock_oh <= w_grant;
      r_last    <= w_last;
    end
  end

  assign bus.out_last = r_last;
`else
  assign w_req = bus.in_valid;
  assign w_adv = w_xfer;
`endif

  // Round-robin scan: first requester at or above the pointer, wrapping
  always_comb begin
    int unsigned v_p;
    int unsigned v_idx;
    logic        v_found;
    w_grant = '0;
    v_p     = 0;
    v_found = 1'b0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (r_ptr[i]) v_p = i;
    end
    for (int unsigned off = 0; off < INPUTS; off++) begin
      v_idx = v_p + off;
      if (v_idx >= INPUTS) v_idx = v_idx - INPUTS;
      if (!v_found && w_req[v_idx]) begin
        w_grant[v_idx] = 1'b1;
        v_found        = 1'b1;
      end
    end
  end

  // One-hot AND-OR data mux
  always_comb begin
    w_mux = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      w_mux = w_mux | ({WIDTH{w_grant[i]}} & bus.in_data[i*WIDTH +: WIDTH]);
    end
  end

  // Output pipeline register and priority pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
      r_ptr   <= {{(INPUTS-1){1'b0}}, 1'b1};
    end else begin
      if (w_load) begin
        if (w_xfer) begin
          r_data  <= w_mux;
          r_grant <= w_grant;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end
      if (w_adv) r_ptr <= {w_grant[INPUTS-2:0], w_grant[INPUTS-1]};
    end
  end

  assign bus.in_ready  = w_grant & {INPUTS{w_load}};
  assign bus.out_data  = r_data;
  assign bus.out_grant = r_grant;
  assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed scoreboard bench for rr_arb_mux (INPUTS=4, WIDTH=8).
module tb_rr_arb_mux;

  logic clk;
  logic rst_n;

  rr_arb_mux_if #(.INPUTS(4), .WIDTH(8)) bus ();

  rr_arb_mux #(.INPUTS(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic [3:0] g;
    logic       l;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, need finish");
    $fatal(1);
  end

  // Monitor: pops an expected beat each time the consumer takes one
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      n_cmp++;
      if ($countones(bus.in_ready) > 1) begin
        n_bad++;
        $display("FAIL in_ready_onehot: got %b need at most one bit", bus.in_ready);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat: got data=%h grant=%b need no beat",
                   bus.out_data, bus.out_grant);
        end else begin
          e = sb.pop_front();
`ifdef RR_ARB_MUX_LOCK_EN
          if (bus.out_data !== e.d || bus.out_grant !== e.g || bus.out_last !== e.l) begin
            n_bad++;
            $display("FAIL beat: got data=%h grant=%b last=%b need data=%h grant=%b last=%b",
                     bus.out_data, bus.out_grant, bus.out_last, e.d, e.g, e.l);
          end
`else
          if (bus.out_data !== e.d || bus.out_grant !== e.g) begin
            n_bad++;
            $display("FAIL beat: got data=%h grant=%b need data=%h grant=%b",
                     bus.out_data, bus.out_grant, e.d, e.g);
          end
`endif
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
    n_cmp++;
    if (got !== need) begin
      n_bad++;
      $display("FAIL %s: got %h need %h", name, got, need);
    end
  endtask

  // One cycle of stimulus; a transfer is expected whenever exp_rdy is nonzero
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic ordy,
                      input logic [3:0] l, input logic [3:0] exp_rdy,
                      input logic [7:0] exp_d, input logic exp_l);
    beat_t b;
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
`ifdef RR_ARB_MUX_LOCK_EN
    bus.in_last   = l;
`else
    if (l == 4'h0) bus.in_valid = v;
`endif
    #2;
    chk("in_ready", {28'd0, bus.in_ready}, {28'd0, exp_rdy});
    if (exp_rdy != 4'b0000) begin
      b.d = exp_d;
      b.g = exp_rdy;
      b.l = exp_l;
      sb.push_back(b);
    end
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef RR_ARB_MUX_LOCK_EN
    bus.in_last   = '0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_data",  {24'd0, bus.out_data},  32'd0);
    chk("reset_grant", {28'd0, bus.out_grant}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    step(4'b0000, 32'h0, 1'b1, 4'hF, 4'b0000, 8'h00, 1'b1);
    step(4'b0000, 32'h0, 1'b1, 4'hF, 4'b0000, 8'h00, 1'b1);
    chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);

    // Fairness: all valid, grants rotate 0,1,2,3,0
    step(4'b1111, 32'h13121110, 1'b1, 4'hF, 4'b0001, 8'h10, 1'b1);
    step(4'b1111, 32'h13121110, 1'b1, 4'hF, 4'b0010, 8'h11, 1'b1);
    step(4'b1111, 32'h13121110, 1'b1, 4'hF, 4'b0100, 8'h12, 1'b1);
    step(4'b1111, 32'h13121110, 1'b1, 4'hF, 4'b1000, 8'h13, 1'b1);
    step(4'b1111, 32'h13121110, 1'b1, 4'hF, 4'b0001, 8'h10, 1'b1);

    // Single requester on channel 2, accepted every cycle
    step(4'b0100, 32'h005A0000, 1'b1, 4'hF, 4'b0100, 8'h5A, 1'b1);
    step(4'b0100, 32'h006B0000, 1'b1, 4'hF, 4'b0100, 8'h6B, 1'b1);
    step(4'b0100, 32'h007C0000, 1'b1, 4'hF, 4'b0100, 8'h7C, 1'b1);
    step(4'b0000, 32'h0,        1'b1, 4'hF, 4'b0000, 8'h00, 1'b1);

    // Wrap/skip: pointer at 3, channels 0 and 1 valid
    step(4'b0011, 32'h00000201, 1'b1, 4'hF, 4'b0001, 8'h01, 1'b1);
    step(4'b0011, 32'h00000201, 1'b1, 4'hF, 4'b0010, 8'h02, 1'b1);
    step(4'b0011, 32'h00000201, 1'b1, 4'hF, 4'b0001, 8'h01, 1'b1);

    // Backpressure: hold for 5 cycles, then consume and capture together
    step(4'b1111, 32'h23222120, 1'b1, 4'hF, 4'b0010, 8'h21, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 32'h23222120, 1'b0, 4'hF, 4'b0000, 8'h00, 1'b1);
      chk("hold_data",  {24'd0, bus.out_data},  32'h21);
      chk("hold_grant", {28'd0, bus.out_grant}, 32'h2);
    end
    step(4'b1111, 32'h23222120, 1'b1, 4'hF, 4'b0100, 8'h22, 1'b1);
    step(4'b0000, 32'h0,        1'b1, 4'hF, 4'b0000, 8'h00, 1'b1);

`ifdef RR_ARB_MUX_LOCK_EN
    // Packet lock: channel 1 sends 3 beats while 0 and 2 also request
    step(4'b0001, 32'h00000030, 1'b1, 4'b0001, 4'b0001, 8'h30, 1'b1);
    step(4'b0111, 32'h00323130, 1'b1, 4'b0000, 4'b0010, 8'h31, 1'b0);
    step(4'b0111, 32'h00324130, 1'b1, 4'b0000, 4'b0010, 8'h41, 1'b0);
    step(4'b0111, 32'h00325130, 1'b1, 4'b0010, 4'b0010, 8'h51, 1'b1);
    step(4'b0101, 32'h00520050, 1'b1, 4'b0101, 4'b0100, 8'h52, 1'b1);
    step(4'b0000, 32'h0,        1'b1, 4'hF,    4'b0000, 8'h00, 1'b1);
`endif

    // Reset mid-operation with a held beat
    step(4'b0001, 32'h00000077, 1'b0, 4'hF, 4'b0001, 8'h77, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = '0;
    chk("held_valid", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_data",  {24'd0, bus.out_data},  32'd0);
    chk("midrst_grant", {28'd0, bus.out_grant}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'b0000, 32'h0,        1'b1, 4'hF, 4'b0000, 8'h00, 1'b1);
    chk("postrst_valid", {31'd0, bus.out_valid}, 32'd0);
    // Pointer back at channel 0
    step(4'b1111, 32'h13121110, 1'b1, 4'hF, 4'b0001, 8'h10, 1'b1);
    step(4'b0000, 32'h0,        1'b1, 4'hF, 4'b0000, 8'h00, 1'b1);
    step(4'b0000, 32'h0,        1'b1, 4'hF, 4'b0000, 8'h00, 1'b1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
